sr_ctrl: RTL and testbench
==========================

SR_CTRL -- requirements
Module: sr_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port alu_req, input, 1 bit: ALU flag-update request.
REQ-004 SHALL have port alu_flags, input, 8 bits: new flag values from the ALU.
REQ-005 SHALL have port alu_mask, input, 8 bits: flag bits the ALU may modify (1 = writable).
REQ-006 SHALL have port sw_req, input, 1 bit: full status-register write request from a move-to-SR instruction.
REQ-007 SHALL have port sw_data, input, 8 bits: value for the software write.
REQ-008 SHALL have port irq_enter, input, 1 bit: interrupt entry request (save SR, then mask).
REQ-009 SHALL have port irq_exit, input, 1 bit: interrupt return request (restore SR).
REQ-010 SHALL have port ack, output, 2 bits: granted source in the cycle after a grant (0 none, 1 alu, 2 sw, 3 irq).
REQ-011 SHALL have port sr_set, output, 8 bits: registered status value that drives the SR register's set input.
REQ-012 SHALL have port stk_err, output, 1 bit: sticky flag for shadow-stack overflow or underflow.

Function
REQ-013 SHALL accept at most one update per cycle, with fixed priority irq_enter/irq_exit > sw_req > alu_req.
REQ-014 SHALL treat irq_enter and irq_exit asserted in the same cycle as a no-op (no stack change, no sr_set change), and shall return ack = 3.
REQ-015 SHALL, on an ALU grant, compute sr_set <= (sr_set & ~alu_mask) | (alu_flags & alu_mask); bit 7 (I) SHALL never be altered by the ALU, regardless of the mask.
REQ-016 SHALL, on a software grant, load sr_set <= sw_data.
REQ-017 SHALL, on irq_enter, push sr_set onto the shadow stack, clear bit 7 and leave bits 6:0 unchanged.
REQ-018 SHALL, on irq_exit, pop the top stack entry into sr_set.
REQ-019 SHALL have a one-cycle grant latency: a request sampled at edge N changes sr_set at edge N, and ack reflects that grant during cycle N+1.
REQ-020 SHALL hold sr_set and drive ack = 0 in every cycle with no request.
REQ-021 SHALL, on a push while the stack is full, set stk_err, leave the stack unchanged and still clear bit 7.
REQ-022 SHALL, on a pop while the stack is empty, set stk_err and leave sr_set unchanged.
REQ-023 SHALL keep stk_err set until reset.
REQ-024 SHALL ignore losing requests; requesters hold req until they see their ack code.

Reset
REQ-025 SHALL, on rst, drive sr_set = 8'h00, ack = 0, stk_err = 0, stack pointer = 0 (empty).
REQ-026 SHALL give rst priority over all requests; a push or pop in flight at reset SHALL be discarded.

Configuration
REQ-027 SHALL, when SR_SHADOW_STACK_EN is defined, implement a 4-entry LIFO shadow stack with a 3-bit occupancy count (0..4).
REQ-028 SHALL, when SR_SHADOW_STACK_EN is undefined, replace the stack with a single shadow register plus a valid bit, giving depth 1 with the same full/empty error rules.

Structure
REQ-029 SHALL take from shared package sr_pkg: SR_I_BIT = 7, SR_STK_DEPTH = 4, and the ack encoding constants.
REQ-030 SHALL place the LIFO in sub-module sr_stack, with ports push, pop, din, dout, full, empty.

Verification
REQ-031 SHALL verify: reset, then alu_req with flags 8'hFF and mask 8'h81 -> sr_set = 8'h01, ack = 1 on the next cycle.
REQ-032 SHALL verify: sw_req with 8'hA5 and alu_req on the same cycle -> sr_set = 8'hA5, ack = 2; the ALU request is granted on the following cycle.
REQ-033 SHALL verify: sr_set = 8'h85, irq_enter, then irq_exit -> sr_set goes 8'h05 then 8'h85.
REQ-034 SHALL verify: five irq_enter with SR_SHADOW_STACK_EN defined -> stk_err rises on the fifth; four irq_exit restore in LIFO order.
REQ-035 SHALL verify: irq_exit on an empty stack -> stk_err = 1 and sr_set unchanged.
REQ-036 SHALL verify: rst asserted in the same cycle as irq_enter -> sr_set = 8'h00 and stack empty.

Source files
------------

// File: rtl/sr_pkg.sv
//------------------------------------------------------------------------------
// Module  : sr_pkg
// Brief   : Shared constants for the status-register update controller.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package sr_pkg;

    localparam int SR_I_BIT     = 7;
    localparam int SR_STK_DEPTH = 4;

    localparam logic [1:0] ACK_NONE = 2'd0;
    localparam logic [1:0] ACK_ALU  = 2'd1;
    localparam logic [1:0] ACK_SW   = 2'd2;
    localparam logic [1:0] ACK_IRQ  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/sr_stack.sv
//------------------------------------------------------------------------------
// Module  : sr_stack
// Brief   : Shadow LIFO for interrupt SR save/restore; 4-entry stack when
//           SR_SHADOW_STACK_EN is defined, otherwise a single shadow register.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module sr_stack
    import sr_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

`ifdef SR_SHADOW_STACK_EN
    localparam logic [2:0] c_DEPTH = 3'(SR_STK_DEPTH);

    logic [7:0] r_mem [0:SR_STK_DEPTH-1];
    logic [2:0] r_cnt;
    logic [1:0] w_top;

    assign w_top = r_cnt[1:0] - 2'd1;
    assign full  = (r_cnt == c_DEPTH);
    assign empty = (r_cnt == 3'd0);
    assign dout  = empty ? 8'h00 : r_mem[w_top];

    // Caller never pushes when full nor pops when empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 3'd0;
        end else if (push) begin
            r_mem[r_cnt[1:0]] <= din;
            r_cnt             <= r_cnt + 3'd1;
        end else if (pop) begin
            r_cnt <= r_cnt - 3'd1;
        end
    end
`else
    logic [7:0] r_shadow;
    logic       r_valid;

    assign full  = r_valid;
    assign empty = ~r_valid;
    assign dout  = r_shadow;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow <= 8'h00;
            r_valid  <= 1'b0;
        end else if (push) begin
            r_shadow <= din;
            r_valid  <= 1'b1;
        end else if (pop) begin
            r_valid <= 1'b0;
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/sr_ctrl.sv
//------------------------------------------------------------------------------
// Module  : sr_ctrl
// Brief   : Status-register update arbiter (irq > sw > alu) with shadow stack;
//           stack depth selected by SR_SHADOW_STACK_EN.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module sr_ctrl
    import sr_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       alu_req,
    input  logic [7:0] alu_flags,
    input  logic [7:0] alu_mask,
    input  logic       sw_req,
    input  logic [7:0] sw_data,
    input  logic       irq_enter,
    input  logic       irq_exit,
    output logic [1:0] ack,
    output logic [7:0] sr_set,
    output logic       stk_err
);

    localparam logic [7:0] c_I_MASK = 8'h01 << SR_I_BIT;

    logic       w_irq_any;
    logic       w_enter;
    logic       w_exit;
    logic       w_push;
    logic       w_pop;
    logic       w_full;
    logic       w_empty;
    logic [7:0] w_dout;
    logic [7:0] w_alu_mask;

    // Simultaneous enter and exit cancel each other.
    assign w_irq_any  = irq_enter | irq_exit;
    assign w_enter    = irq_enter & ~irq_exit;
    assign w_exit     = irq_exit & ~irq_enter;
    assign w_push     = ~rst & w_enter & ~w_full;
    assign w_pop      = ~rst & w_exit & ~w_empty;
    assign w_alu_mask = alu_mask & ~c_I_MASK;

    sr_stack u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (sr_set),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_set  <= 8'h00;
            ack     <= ACK_NONE;
            stk_err <= 1'b0;
        end else begin
            ack <= ACK_NONE;
            if (w_irq_any) begin
                ack <= ACK_IRQ;
                if (w_enter) begin
                    sr_set[SR_I_BIT] <= 1'b0;
                    if (w_full)
                        stk_err <= 1'b1;
                end else if (w_exit) begin
                    if (w_empty)
                        stk_err <= 1'b1;
                    else
                        sr_set <= w_dout;
                end
            end else if (sw_req) begin
                ack    <= ACK_SW;
                sr_set <= sw_data;
            end else if (alu_req) begin
                ack    <= ACK_ALU;
                sr_set <= (sr_set & ~w_alu_mask) | (alu_flags & w_alu_mask);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sr_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_sr_ctrl
// Brief   : Directed self-checking bench for sr_ctrl; stack depth follows
//           SR_SHADOW_STACK_EN.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sr_ctrl;

`ifdef SR_SHADOW_STACK_EN
    localparam int c_DEPTH = 4;
`else
    localparam int c_DEPTH = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       alu_req;
    logic [7:0] alu_flags;
    logic [7:0] alu_mask;
    logic       sw_req;
    logic [7:0] sw_data;
    logic       irq_enter;
    logic       irq_exit;
    logic [1:0] ack;
    logic [7:0] sr_set;
    logic       stk_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] r_vals [0:c_DEPTH];

    always #5 clk = ~clk;

    sr_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .alu_req   (alu_req),
        .alu_flags (alu_flags),
        .alu_mask  (alu_mask),
        .sw_req    (sw_req),
        .sw_data   (sw_data),
        .irq_enter (irq_enter),
        .irq_exit  (irq_exit),
        .ack       (ack),
        .sr_set    (sr_set),
        .stk_err   (stk_err)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        alu_req = 0; alu_flags = 0; alu_mask = 0;
        sw_req = 0; sw_data = 0; irq_enter = 0; irq_exit = 0;
    endtask

    // One edge, then sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sw_write(input logic [7:0] v);
        sw_req = 1; sw_data = v;
        tick();
        sw_req = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    initial begin
        idle_inputs();
        do_reset();
        check("rst_sr", sr_set, 8'h00);
        check("rst_ack", {6'd0, ack}, 8'd0);
        check("rst_err", {7'd0, stk_err}, 8'd0);

        // ALU cannot touch the I bit even when masked in
        alu_req = 1; alu_flags = 8'hFF; alu_mask = 8'h81;
        tick();
        idle_inputs();
        check("alu_sr", sr_set, 8'h01);
        check("alu_ack", {6'd0, ack}, 8'd1);
        tick();
        check("idle_ack", {6'd0, ack}, 8'd0);
        check("idle_sr", sr_set, 8'h01);

        // sw beats alu; alu then granted next cycle
        sw_req = 1; sw_data = 8'hA5;
        alu_req = 1; alu_flags = 8'h0F; alu_mask = 8'h0F;
        tick();
        check("sw_sr", sr_set, 8'hA5);
        check("sw_ack", {6'd0, ack}, 8'd2);
        sw_req = 0;
        tick();
        idle_inputs();
        check("alu2_sr", sr_set, 8'hAF);
        check("alu2_ack", {6'd0, ack}, 8'd1);

        sw_write(8'h80);
        alu_req = 1; alu_flags = 8'h00; alu_mask = 8'hFF;
        tick();
        idle_inputs();
        check("alu_ibit_sr", sr_set, 8'h80);

        // enter / exit round trip
        sw_write(8'h85);
        irq_enter = 1;
        tick();
        irq_enter = 0;
        check("enter_sr", sr_set, 8'h05);
        check("enter_ack", {6'd0, ack}, 8'd3);
        irq_exit = 1;
        tick();
        irq_exit = 0;
        check("exit_sr", sr_set, 8'h85);
        check("exit_ack", {6'd0, ack}, 8'd3);
        check("exit_err", {7'd0, stk_err}, 8'd0);

        irq_enter = 1; irq_exit = 1;
        tick();
        idle_inputs();
        check("both_sr", sr_set, 8'h85);
        check("both_ack", {6'd0, ack}, 8'd3);
        check("both_err", {7'd0, stk_err}, 8'd0);

        // Fill past capacity, then drain in LIFO order
        for (int i = 0; i <= c_DEPTH; i++) begin
            r_vals[i] = 8'h90 + 8'(i);
            sw_write(r_vals[i]);
            irq_enter = 1;
            tick();
            irq_enter = 0;
            check("push_sr", sr_set, r_vals[i] & 8'h7F);
            check("push_err", {7'd0, stk_err}, (i == c_DEPTH) ? 8'd1 : 8'd0);
        end
        for (int j = 0; j < c_DEPTH; j++) begin
            irq_exit = 1;
            tick();
            irq_exit = 0;
            check("pop_sr", sr_set, r_vals[c_DEPTH-1-j]);
        end

        // Underflow on an empty stack
        do_reset();
        check("rst2_err", {7'd0, stk_err}, 8'd0);
        sw_write(8'h3C);
        irq_exit = 1;
        tick();
        irq_exit = 0;
        check("under_sr", sr_set, 8'h3C);
        check("under_err", {7'd0, stk_err}, 8'd1);
        tick();
        check("sticky_err", {7'd0, stk_err}, 8'd1);

        // Reset wins over a concurrent push
        sw_write(8'h77);
        rst = 1; irq_enter = 1;
        tick();
        rst = 0; irq_enter = 0;
        check("rstpush_sr", sr_set, 8'h00);
        check("rstpush_ack", {6'd0, ack}, 8'd0);
        check("rstpush_err", {7'd0, stk_err}, 8'd0);
        irq_exit = 1;
        tick();
        irq_exit = 0;
        check("rstpush_empty_err", {7'd0, stk_err}, 8'd1);
        check("rstpush_empty_sr", sr_set, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
